flow_bram_readout: RTL and testbench

//  Reader side of the u/v flow-result BRAM that optical_flow_ISP_core fills each frame.
//  On start: scans BRAM row-major (BRAM_Height x BRAM_Width), reads each packed {u,v} word,

---
 rtl/flow_bram_readout_pkg.sv | 16 +
 rtl/flow_readout_fifo2.sv | 52 +++++
 rtl/flow_bram_readout.sv | 169 ++++++++++++++++
 tb/tb_flow_bram_readout.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flow_bram_readout_pkg.sv
// Shared definitions for the flow-result BRAM readout: FSM encoding and the
// field positions of u and v inside a packed BRAM word.
package flow_bram_readout_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDrain,
        StDone
    } readout_state_e;

    // Packed word is {u, v}: field index times u_v_Bit_Size gives the LSB of each field.
    localparam int unsigned UvFieldU = 1;
    localparam int unsigned UvFieldV = 0;

endpackage

// File: rtl/flow_readout_fifo2.sv
// Two-entry valid/ready FIFO that buffers BRAM read results ahead of the output
// port and reports its occupancy so the reader can meter its requests.
module flow_readout_fifo2 #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [Width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign occupancy = count_q;
    assign pop       = out_valid && out_ready;
    assign push      = in_valid && ((count_q != 2'd2) || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/flow_bram_readout.sv
// Scans the u/v flow BRAM row-major and streams {u,v,x,y,sof,eol,eof} beats over
// valid/ready. Define FLOW_READOUT_STATS_EN to add the stat_nonzero_cnt counter.
module flow_bram_readout
    import flow_bram_readout_pkg::*;
#(
    parameter int unsigned u_v_Bit_Size              = 10,
    parameter int unsigned BRAM_Height               = 240,
    parameter int unsigned BRAM_Width                = 320,
    parameter int unsigned BRAM_Height_Bit_Size      = $clog2(BRAM_Height),
    parameter int unsigned BRAM_Width_Bit_Size       = $clog2(BRAM_Width),
    parameter int unsigned BRAM_Data_Bit_Size_for_uv = u_v_Bit_Size * 2,
    parameter int unsigned BRAM_Address_Bit_Size     = $clog2(BRAM_Height * BRAM_Width)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 bram_rd_en,
    output logic [BRAM_Address_Bit_Size-1:0]     bram_rd_addr,
    input  logic [BRAM_Data_Bit_Size_for_uv-1:0] bram_rd_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [u_v_Bit_Size-1:0]       out_u,
    output logic signed [u_v_Bit_Size-1:0]       out_v,
    output logic [BRAM_Width_Bit_Size-1:0]       out_x,
    output logic [BRAM_Height_Bit_Size-1:0]      out_y,
    output logic                                 out_sof,
    output logic                                 out_eol,
    output logic                                 out_eof
`ifdef FLOW_READOUT_STATS_EN
    ,
    output logic [BRAM_Address_Bit_Size:0]       stat_nonzero_cnt
`endif
);

    localparam int unsigned UW = u_v_Bit_Size;
    localparam int unsigned DW = BRAM_Data_Bit_Size_for_uv;
    localparam int unsigned XW = BRAM_Width_Bit_Size;
    localparam int unsigned YW = BRAM_Height_Bit_Size;
    localparam int unsigned AW = BRAM_Address_Bit_Size;
    localparam int unsigned PW = DW + XW + YW + 3;

    readout_state_e state_q, state_d;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [AW-1:0] addr_q;
    logic          inflight_q;
    logic [XW-1:0] pend_x_q;
    logic [YW-1:0] pend_y_q;
    logic          pend_sof_q, pend_eol_q, pend_eof_q;

    logic          start_acc;
    logic          x_last, y_last, scan_last;
    logic          credit_ok, drain_empty;
    logic          fifo_pop;
    logic [1:0]    occupancy;
    logic [PW-1:0] fifo_in, fifo_out;

    assign start_acc = (state_q == StIdle) && start;
    assign x_last    = (x_q == XW'(BRAM_Width - 1));
    assign y_last    = (y_q == YW'(BRAM_Height - 1));
    assign scan_last = x_last && y_last;
    assign fifo_pop  = out_valid && out_ready;

    // A beat leaving this cycle frees its slot, which keeps one beat per cycle flowing.
    assign credit_ok   = ({1'b0, occupancy} + {2'b0, inflight_q}) < (3'd2 + {2'b0, fifo_pop});
    assign drain_empty = !inflight_q &&
                         ((occupancy == 2'd0) || ((occupancy == 2'd1) && fifo_pop));

    always_comb begin
        state_d    = state_q;
        bram_rd_en = 1'b0;
        unique case (state_q)
            StIdle:  if (start) state_d = StRead;
            StRead: begin
                if (credit_ok) begin
                    bram_rd_en = 1'b1;
                    if (scan_last) state_d = StDrain;
                end
            end
            StDrain: if (drain_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign bram_rd_addr = addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            pend_sof_q <= 1'b0;
            pend_eol_q <= 1'b0;
            pend_eof_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= bram_rd_en;
            if (start_acc) begin
                x_q    <= '0;
                y_q    <= '0;
                addr_q <= '0;
            end else if (bram_rd_en) begin
                // Position markers travel alongside the read so they meet the data.
                pend_x_q   <= x_q;
                pend_y_q   <= y_q;
                pend_sof_q <= (x_q == '0) && (y_q == '0);
                pend_eol_q <= x_last;
                pend_eof_q <= scan_last;
                addr_q     <= addr_q + AW'(1);
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

    assign fifo_in = {pend_eof_q, pend_eol_q, pend_sof_q, pend_y_q, pend_x_q, bram_rd_data};

    flow_readout_fifo2 #(
        .Width (PW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (inflight_q),
        .in_data   (fifo_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fifo_out),
        .occupancy (occupancy)
    );

    assign out_u   = fifo_out[UvFieldU*UW +: UW];
    assign out_v   = fifo_out[UvFieldV*UW +: UW];
    assign out_x   = fifo_out[DW +: XW];
    assign out_y   = fifo_out[DW+XW +: YW];
    assign out_sof = fifo_out[DW+XW+YW];
    assign out_eol = fifo_out[DW+XW+YW+1];
    assign out_eof = fifo_out[DW+XW+YW+2];

`ifdef FLOW_READOUT_STATS_EN
    logic [AW:0] stat_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_q <= '0;
        end else if (start_acc) begin
            stat_q <= '0;
        end else if (fifo_pop && ((out_u != '0) || (out_v != '0))) begin
            stat_q <= stat_q + (AW+1)'(1);
        end
    end

    assign stat_nonzero_cnt = stat_q;
`endif

endmodule

// File: tb/tb_flow_bram_readout.sv
// Self-checking bench for flow_bram_readout on a 2x3 BRAM; expected beats come
// from a literal table and from a row-major model of the BRAM contents.
`timescale 1ns/1ps
module tb_flow_bram_readout;

    localparam int unsigned UV = 10;
    localparam int unsigned H  = 2;
    localparam int unsigned W  = 3;
    localparam int unsigned N  = H * W;
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned XW = $clog2(W);
    localparam int unsigned YW = $clog2(H);
    localparam int unsigned DW = 2 * UV;

    typedef struct {
        logic [UV-1:0] u;
        logic [UV-1:0] v;
        int            x;
        int            y;
        logic          sof;
        logic          eol;
        logic          eof;
        int            cyc;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 busy, done, bram_rd_en;
    logic [AW-1:0]        bram_rd_addr;
    logic [DW-1:0]        bram_rd_data = '0;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [UV-1:0] out_u, out_v;
    logic [XW-1:0]        out_x;
    logic [YW-1:0]        out_y;
    logic                 out_sof, out_eol, out_eof;
`ifdef FLOW_READOUT_STATS_EN
    logic [AW:0]          stat_cnt;
`endif

    logic [DW-1:0] mem [N];
    beat_t         got_q[$];
    beat_t         exp_q[$];
    beat_t         tbl[N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rcyc = 0;
    int rd_cnt, acc_cnt, done_cnt, done_cyc;
    int ready_mode = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] prev_payload = '0;

    flow_bram_readout #(
        .u_v_Bit_Size (UV),
        .BRAM_Height  (H),
        .BRAM_Width   (W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .bram_rd_en       (bram_rd_en),
        .bram_rd_addr     (bram_rd_addr),
        .bram_rd_data     (bram_rd_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_u            (out_u),
        .out_v            (out_v),
        .out_x            (out_x),
        .out_y            (out_y),
        .out_sof          (out_sof),
        .out_eol          (out_eol),
        .out_eof          (out_eof)
`ifdef FLOW_READOUT_STATS_EN
        ,
        .stat_nonzero_cnt (stat_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    // BRAM with one cycle of read latency.
    always_ff @(posedge clk) begin
        if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_beat(input beat_t b);
        return {33'd0, b.u, b.v, 4'(b.x), 4'(b.y), b.sof, b.eol, b.eof};
    endfunction

    // Reference: row-major walk of the BRAM image.
    task automatic build_model();
        beat_t b;
        exp_q.delete();
        for (int y = 0; y < int'(H); y++) begin
            for (int x = 0; x < int'(W); x++) begin
                b.u   = mem[y*W+x][DW-1:UV];
                b.v   = mem[y*W+x][UV-1:0];
                b.x   = x;
                b.y   = y;
                b.sof = (x == 0) && (y == 0);
                b.eol = (x == int'(W) - 1);
                b.eof = (x == int'(W) - 1) && (y == int'(H) - 1);
                b.cyc = 0;
                exp_q.push_back(b);
            end
        end
    endtask

    function automatic int model_nonzero();
        int n = 0;
        for (int i = 0; i < int'(N); i++) if (mem[i] != '0) n++;
        return n;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        rd_cnt   = 0;
        acc_cnt  = 0;
        done_cnt = 0;
        done_cyc = -1;
    endtask

    // Monitor on the falling edge: handshakes, stall stability, read credit.
    initial forever begin
        beat_t b;
        @(negedge clk);
        cyc++;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (bram_rd_en) rd_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall_prev)
                check("stall_hold", {out_valid, out_u, out_v, out_x, out_y, out_sof, out_eol,
                                     out_eof}, prev_payload);
            stall_prev   = out_valid && !out_ready;
            prev_payload = 64'({out_valid, out_u, out_v, out_x, out_y, out_sof, out_eol,
                                out_eof});
            if (out_valid && out_ready) begin
                b.u = out_u; b.v = out_v; b.x = int'(out_x); b.y = int'(out_y);
                b.sof = out_sof; b.eol = out_eol; b.eof = out_eof; b.cyc = cyc;
                got_q.push_back(b);
                acc_cnt++;
            end
            if (bram_rd_en) check("outstanding_le2", 64'(rd_cnt - acc_cnt <= 2), 64'd1);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        rcyc++;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = rcyc[0];
            2:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic start_scan();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic wait_done(input int extra_start);
        for (int k = 0; k < 300; k++) begin
            if (done_cnt > 0) break;
            @(posedge clk); #1;
            start = (k == extra_start);
            if (ready_mode == 2 && k == 20) begin
                check("reads_while_blocked", 64'(rd_cnt), 64'd2);
                ready_mode = 0;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("beat_count", 64'(got_q.size()), 64'(N));
        if (got_q.size() == N)
            check("done_after_last", 64'(done_cyc), 64'(got_q[N-1].cyc + 1));
    endtask

    task automatic compare_model();
        build_model();
        for (int i = 0; i < int'(N) && i < got_q.size(); i++)
            check($sformatf("model_beat%0d", i), pack_beat(got_q[i]), pack_beat(exp_q[i]));
    endtask

    task automatic fill_default();
        for (int i = 0; i < int'(N); i++) begin
            mem[i][DW-1:UV] = UV'(i);
            mem[i][UV-1:0]  = UV'(-i);
        end
    endtask

    initial begin
        // {u, v, x, y, sof, eol, eof} for word[i] = {i, -i}
        tbl[0] = '{10'h000, 10'h000, 0, 0, 1'b1, 1'b0, 1'b0, 0};
        tbl[1] = '{10'h001, 10'h3FF, 1, 0, 1'b0, 1'b0, 1'b0, 0};
        tbl[2] = '{10'h002, 10'h3FE, 2, 0, 1'b0, 1'b1, 1'b0, 0};
        tbl[3] = '{10'h003, 10'h3FD, 0, 1, 1'b0, 1'b0, 1'b0, 0};
        tbl[4] = '{10'h004, 10'h3FC, 1, 1, 1'b0, 1'b0, 1'b0, 0};
        tbl[5] = '{10'h005, 10'h3FB, 2, 1, 1'b0, 1'b1, 1'b1, 0};

        fill_default();
        reset = 1'b1;
        start = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {busy, done, bram_rd_en, out_valid, out_sof, out_eol, out_eof},
              7'd0);
        check("rst_payload", {out_u, out_v, out_x, out_y, bram_rd_addr}, '0);
        reset = 1'b0;

        // 1: full-rate scan with latency and table check
        clear_mon();
        ready_mode = 0;
        start_scan();
        @(negedge clk);
        check("lat_t1", {busy, bram_rd_en, 4'(bram_rd_addr), out_valid}, {1'b1, 1'b1, 4'd0, 1'b0});
        @(negedge clk);
        check("lat_t2", {bram_rd_en, 4'(bram_rd_addr), out_valid}, {1'b1, 4'd1, 1'b0});
        @(negedge clk);
        check("lat_t3", {out_valid, out_sof}, 2'b11);
        wait_done(-1);
        for (int i = 0; i < int'(N) && i < got_q.size(); i++)
            check($sformatf("table_beat%0d", i), pack_beat(got_q[i]), pack_beat(tbl[i]));
        if (got_q.size() == N)
            check("contiguous", 64'(got_q[N-1].cyc - got_q[0].cyc), 64'(N - 1));

        // 2: alternating back-pressure
        clear_mon();
        ready_mode = 1;
        start_scan();
        wait_done(-1);
        compare_model();

        // 3: long stall right after start
        clear_mon();
        ready_mode = 2;
        start_scan();
        wait_done(-1);
        compare_model();

        // 4: extra start while busy
        clear_mon();
        ready_mode = 1;
        start_scan();
        wait_done(3);
        compare_model();

        // 5: reset after beat 3, then a clean frame
        clear_mon();
        ready_mode = 0;
        start_scan();
        for (int k = 0; k < 50 && acc_cnt < 4; k++) @(posedge clk);
        check("reached_beat3", 64'(acc_cnt >= 4), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("reset_mid_scan", {out_valid, busy, bram_rd_en}, 3'd0);
        @(posedge clk); #1 reset = 1'b0;
        clear_mon();
        start_scan();
        wait_done(-1);
        compare_model();
        if (got_q.size() > 0) check("restart_sof", 64'(got_q[0].sof), 64'd1);

        // Randomized contents and back-pressure
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'(N); i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            clear_mon();
            ready_mode = 3;
            start_scan();
            wait_done(-1);
            compare_model();
`ifdef FLOW_READOUT_STATS_EN
            check("stat_random", 64'(stat_cnt), 64'(model_nonzero()));
`endif
        end

`ifdef FLOW_READOUT_STATS_EN
        // 6: nonzero statistics
        for (int i = 0; i < int'(N); i++) mem[i] = (i % 2 == 0) ? '0 : DW'(i * 37 + 1);
        clear_mon();
        ready_mode = 1;
        start_scan();
        wait_done(-1);
        check("stat_after_done", 64'(stat_cnt), 64'(model_nonzero()));
        clear_mon();
        ready_mode = 0;
        start_scan();
        @(negedge clk);
        check("stat_cleared", 64'(stat_cnt), 64'd0);
        wait_done(-1);
        check("stat_second", 64'(stat_cnt), 64'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
